// File: rtl/rhd_cmd_sequencer.sv
// rhd_cmd_sequencer
//   Command sequencer for rhd_spi_master. One SPI transaction is paced every
//   PERIOD_CYCLES clocks. A frame is NUM_CHANNELS CONVERT commands followed by
//   two FLUSH_CMD slots. Each returned A/B die result answers the command sent
//   two slots earlier, so results are realigned before they go out as tagged
//   samples on a single-entry valid/ready output register.
//
// Ports
//   clk, rstn            system clock, asynchronous active-low reset
//   enable               run request (level); a running frame always completes
//   spi_start            one-cycle start pulse to the master
//   spi_data_in[15:0]    command word, held until the next start
//   spi_done             master DONE level
//   spi_a_data[15:0]     A-die result, valid when spi_done rises
//   spi_b_data[15:0]     B-die result, valid when spi_done rises
//   sample_valid/ready   output stream handshake
//   sample_channel[5:0]  channel of the held sample
//   sample_a/b[15:0]     A/B-die sample
//   sample_first         held sample is channel 0
//   overflow             sticky: a sample was dropped, output register full
//   timing_err           sticky: period expired before the master finished
//   running              sequencer is active (not IDLE)
module rhd_cmd_sequencer #(
    parameter int unsigned NUM_CHANNELS  = 32,
    parameter int unsigned PERIOD_CYCLES = 256,
    parameter logic [15:0] FLUSH_CMD     = 16'hE800
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    output logic        spi_start,
    output logic [15:0] spi_data_in,
    input  logic        spi_done,
    input  logic [15:0] spi_a_data,
    input  logic [15:0] spi_b_data,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic [5:0]  sample_channel,
    output logic [15:0] sample_a,
    output logic [15:0] sample_b,
    output logic        sample_first,
    output logic        overflow,
    output logic        timing_err,
    output logic        running
);

    localparam int unsigned    CW         = $clog2(PERIOD_CYCLES);
    localparam logic [CW-1:0]  CNT_RELOAD = CW'(PERIOD_CYCLES - 1);
    localparam logic [5:0]     N_SLOT     = 6'(NUM_CHANNELS);
    localparam logic [5:0]     LAST_SLOT  = 6'(NUM_CHANNELS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_WAIT_IDLE
    } state_t;

    state_t         state, state_d;
    logic [5:0]     slot, slot_d;
    logic [CW-1:0]  cnt;
    logic           done_q;
    logic           done_rise;
    logic           issue_d;
    logic [15:0]    cmd_d;
    logic           capture;
    logic           keep;

    assign done_rise = spi_done & ~done_q;
    assign capture   = (state == ST_WAIT_DONE) & done_rise;
    // Slots 0 and 1 return results for commands of the previous frame.
    assign keep      = capture & (slot >= 6'd2);
    assign running   = (state != ST_IDLE);

    always_comb begin
        state_d = state;
        slot_d  = slot;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    slot_d  = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (done_rise) begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (!spi_done && (cnt == '0)) begin
                    if (slot == LAST_SLOT) begin
                        slot_d  = '0;
                        state_d = enable ? ST_ISSUE : ST_IDLE;
                    end else begin
                        slot_d  = slot + 6'd1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                slot_d  = '0;
            end
        endcase
    end

    // The start pulse, command word and period reload are registered on entry
    // to ISSUE, so the pulse is high exactly while the FSM sits in ISSUE and
    // consecutive starts are PERIOD_CYCLES apart.
    assign issue_d = (state_d == ST_ISSUE);
    assign cmd_d   = (slot_d < N_SLOT) ? {2'b00, slot_d, 8'h00} : FLUSH_CMD;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            slot        <= '0;
            cnt         <= '0;
            done_q      <= 1'b0;
            spi_start   <= 1'b0;
            spi_data_in <= '0;
            timing_err  <= 1'b0;
        end else begin
            state     <= state_d;
            slot      <= slot_d;
            done_q    <= spi_done;
            spi_start <= issue_d;
            if (issue_d) begin
                spi_data_in <= cmd_d;
                cnt         <= CNT_RELOAD;
            end else if ((state != ST_IDLE) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if ((state == ST_WAIT_DONE) && (cnt == '0)) begin
                timing_err <= 1'b1;
            end
        end
    end

    // Single-entry output register. A capture landing on a full register is
    // accepted only if the held sample leaves in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sample_valid   <= 1'b0;
            sample_channel <= '0;
            sample_a       <= '0;
            sample_b       <= '0;
            sample_first   <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            if (keep && (!sample_valid || sample_ready)) begin
                sample_valid   <= 1'b1;
                sample_channel <= slot - 6'd2;
                sample_a       <= spi_a_data;
                sample_b       <= spi_b_data;
                sample_first   <= (slot == 6'd2);
            end else if (keep) begin
                overflow <= 1'b1;
            end else if (sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule
